// File: rtl/execute_arbiter_pkg.sv
// Shared definitions for the execute arbiter and its dispatch-side producers.
//   log2up   : index width helper, never narrower than one bit
//   rr_next  : round-robin successor with explicit wrap (any requester count)
//   Pkt*     : execute-packet layout, packed as {payload, sop, eop}
package execute_arbiter_pkg;

  localparam int unsigned PktEopBit = 0;
  localparam int unsigned PktSopBit = 1;
  localparam int unsigned PktMetaW  = 2;

  function automatic int unsigned log2up(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned pkt_width(input int unsigned dataw);
    return dataw + PktMetaW;
  endfunction

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/execute_arbiter_rr_lock_arbiter.sv
// Round-robin arbiter with instruction-granularity locking.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   valid       : per-requester packet valid
//   sop, eop    : per-requester packet boundaries
//   can_accept  : downstream stage can take a packet this cycle
//   grant       : one-hot (or zero) accept back to requesters
//   grant_idx   : index of the current winner (meaningful when grant_valid)
//   grant_valid : winner has a valid packet
//   locked      : grant held mid-instruction
module execute_arbiter_rr_lock_arbiter
  import execute_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQS = 4,
  localparam int unsigned REQ_W = log2up(NUM_REQS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] valid,
  input  logic [NUM_REQS-1:0] sop,
  input  logic [NUM_REQS-1:0] eop,
  input  logic                can_accept,
  output logic [NUM_REQS-1:0] grant,
  output logic [REQ_W-1:0]    grant_idx,
  output logic                grant_valid,
  output logic                locked
);

  logic [REQ_W-1:0] rr_ptr_q;
  logic [REQ_W-1:0] lock_idx_q;
  logic             locked_q;
  logic [REQ_W-1:0] win_idx;
  logic             win_found;
  logic             fire;
  int unsigned      cand;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      cand = (32'(rr_ptr_q) + i) % NUM_REQS;
      if (!win_found && valid[cand[REQ_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[REQ_W-1:0];
      end
    end
    // A locked requester keeps the grant even while idle; nobody else may slip in.
    if (locked_q) begin
      win_idx   = lock_idx_q;
      win_found = valid[lock_idx_q];
    end
  end

  assign fire        = win_found && can_accept;
  assign grant       = fire ? (NUM_REQS'(1) << win_idx) : '0;
  assign grant_idx   = win_idx;
  assign grant_valid = win_found;
  assign locked      = locked_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q   <= '0;
      lock_idx_q <= '0;
      locked_q   <= 1'b0;
    end else if (fire) begin
      if (eop[win_idx]) begin
        locked_q <= 1'b0;
        rr_ptr_q <= REQ_W'(rr_next(32'(win_idx), NUM_REQS));
      end else begin
        locked_q   <= 1'b1;
        lock_idx_q <= win_idx;
      end
    end
  end

  // Upstream must not open a new instruction before closing the locked one.
  a_no_sop_while_locked : assert property (@(posedge clk) disable iff (reset)
    !(locked_q && fire && sop[lock_idx_q]));

  a_grant_onehot0 : assert property (@(posedge clk) disable iff (reset) $onehot0(grant));

endmodule

// File: rtl/execute_arbiter.sv
// Shares one execute-unit input port among NUM_REQS dispatch channels.
// Round-robin at instruction granularity, optional registered output stage.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   valid_in/data_in    : per-requester packet valid and payload (DATAW each)
//   sop_in/eop_in       : per-requester instruction boundaries
//   ready_in            : per-requester accept (one-hot or zero)
//   valid_out/data_out  : granted packet toward the functional unit
//   sop_out/eop_out     : forwarded boundaries
//   idx_out             : source requester of the forwarded packet
//   ready_out           : downstream accept
//   locked              : grant held mid-instruction
module execute_arbiter
  import execute_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQS = 4,
  parameter int unsigned DATAW    = 64,
  parameter int unsigned OUT_REG  = 1,
  localparam int unsigned REQ_W = log2up(NUM_REQS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQS-1:0]       valid_in,
  input  logic [NUM_REQS*DATAW-1:0] data_in,
  input  logic [NUM_REQS-1:0]       sop_in,
  input  logic [NUM_REQS-1:0]       eop_in,
  output logic [NUM_REQS-1:0]       ready_in,
  output logic                      valid_out,
  output logic [DATAW-1:0]          data_out,
  output logic                      sop_out,
  output logic                      eop_out,
  output logic [REQ_W-1:0]          idx_out,
  input  logic                      ready_out,
  output logic                      locked
);

  // Stage word: {source index, payload, sop, eop}
  localparam int unsigned PKT_W = REQ_W + pkt_width(DATAW);

  logic [NUM_REQS-1:0] grant;
  logic [REQ_W-1:0]    grant_idx;
  logic                grant_valid;
  logic                can_accept;
  logic [DATAW-1:0]    sel_data;
  logic [PKT_W-1:0]    pkt_in;
  logic [PKT_W-1:0]    pkt_out;

  execute_arbiter_rr_lock_arbiter #(
    .NUM_REQS (NUM_REQS)
  ) u_arb (
    .clk         (clk),
    .reset       (reset),
    .valid       (valid_in),
    .sop         (sop_in),
    .eop         (eop_in),
    .can_accept  (can_accept),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .locked      (locked)
  );

  assign ready_in = grant;
  assign sel_data = data_in[32'(grant_idx) * DATAW +: DATAW];
  assign pkt_in   = {grant_idx, sel_data, sop_in[grant_idx], eop_in[grant_idx]};

  if (OUT_REG != 0) begin : g_out_reg
    logic             valid_q;
    logic [PKT_W-1:0] pkt_q;

    // Pipe register: refill in the same cycle the held packet drains.
    assign can_accept = ~valid_q | ready_out;

    always_ff @(posedge clk) begin
      if (reset) begin
        valid_q <= 1'b0;
      end else if (can_accept) begin
        valid_q <= grant_valid;
      end
    end

    always_ff @(posedge clk) begin
      if (can_accept && grant_valid) begin
        pkt_q <= pkt_in;
      end
    end

    assign valid_out = valid_q;
    assign pkt_out   = pkt_q;
  end else begin : g_out_comb
    assign can_accept = ready_out;
    assign valid_out  = grant_valid;
    assign pkt_out    = pkt_in;
  end

  assign idx_out  = pkt_out[PKT_W-1 -: REQ_W];
  assign data_out = pkt_out[PktMetaW +: DATAW];
  assign sop_out  = pkt_out[PktSopBit];
  assign eop_out  = pkt_out[PktEopBit];

endmodule

// File: doc/execute_arbiter.md
Name: execute_arbiter

Overview:
- Shares one execute-unit input port among NUM_REQS execute channels produced by dispatch blocks.
- Performs round-robin arbitration at instruction granularity: once a multi-packet instruction (sop..eop sequence) is granted, the grant stays locked to that requester until its eop packet fires.
- Drives a single execute channel toward the functional unit, tagged with the source index, behind an optional registered output stage.

Parameters:
- NUM_REQS, 4, number of requesting execute channels (>=1; NUM_REQS=1 degenerates to pass-through plus output stage)
- DATAW, 64, payload width per packet excluding sop/eop
- OUT_REG, 1, 0 = combinational output path; 1 = one registered pipe stage on output
- REQ_W, LOG2UP(NUM_REQS), derived localparam, width of source index

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- valid_in  input  NUM_REQS  per-requester packet valid
- data_in  input  NUM_REQS*DATAW  per-requester packet payload
- sop_in  input  NUM_REQS  first packet of instruction
- eop_in  input  NUM_REQS  last packet of instruction
- ready_in  output  NUM_REQS  per-requester accept (one-hot or zero)
- valid_out  output  1  granted packet valid
- data_out  output  DATAW  granted payload
- sop_out  output  1  forwarded sop
- eop_out  output  1  forwarded eop
- idx_out  output  REQ_W  index of granting requester
- ready_out  input  1  downstream accept
- locked  output  1  status: grant held mid-instruction

Behaviour:
- Single clock clk; reset is synchronous, active-high.
- Reset values: valid_out=0, locked=0, rr pointer=0, lock index=0. data_out, sop_out, eop_out and idx_out are don't-care while valid_out=0.
- Fire definitions:
  - Input fire: valid_in[i] && ready_in[i].
  - Output fire: valid_out && ready_out.
- Arbitration when unlocked:
  - Winner = first valid requester scanning from the rr pointer upward, with wrap-around.
  - Requester i is ready only if i is the winner and the stage is able to accept.
- Stage can accept:
  - OUT_REG=0: ready_out.
  - OUT_REG=1: ~valid_out || ready_out (pipe register; full throughput, no bubble).
- Lock:
  - Set: on input fire with eop_in=0. Lock index = firing requester.
  - While locked: only the lock index may be granted, even if it is idle. Other requesters see ready_in=0, and no switching occurs.
  - Clear: on input fire of the lock index with eop_in=1.
- RR pointer:
  - Updated only on input fire with eop_in=1, to (winner+1) mod NUM_REQS. Non-power-of-2 NUM_REQS wraps explicitly.
  - A single-packet instruction (sop=1, eop=1) advances the pointer and never locks.
- Latency:
  - OUT_REG=0: 0 cycles.
  - OUT_REG=1: 1 cycle input fire to valid_out.
  - Downstream stall holds valid_out and data stable. No packet is dropped or duplicated.
- Simultaneous events: eop fire and new sop arriving in the same cycle. The lock clears and the pointer advances at the clock edge; the new instruction competes from the next cycle.
- Reset mid-lock clears the lock and any held output packet. Upstream is responsible for flushing on the same reset.
- Protocol checks (simulation-only assertions):
  - sop_in=1 from the locked requester before its eop.
  - ready_in not one-hot-or-zero.
  - valid_in deasserted after being presented without fire is allowed; no check.

Decomposition:
- Shared package: REQ_W helper via existing LOG2UP, and the execute-packet struct layout (payload, sop, eop) so dispatch and arbiter agree.
- Natural sub-module: rr_lock_arbiter (NUM_REQS), combinational grant plus pointer/lock state.
- Output stage reuses the existing pipe-register/elastic-buffer primitive selected by OUT_REG.

Test Plan:
- Reset, then all four requesters valid with sop=eop=1, ready_out=1, OUT_REG=1 -> grants in order idx 0,1,2,3,0, one per cycle; valid_out first high 1 cycle after reset release plus first fire.
- Req1 sends 3-packet instruction (sop, mid, eop); req0/req2 valid throughout -> idx_out=1 for three consecutive packets, locked=1 after first fire, cleared after eop; next grant idx 2.
- Locked on req3; req3 drops valid for 2 cycles while req0 valid -> ready_in=0000, valid_out=0 during gap; resumes with req3 eop, then req0 granted.
- ready_out held low 3 cycles with a packet in the output stage -> data_out/idx_out stable, ready_in all 0 (OUT_REG=1), no loss; release -> continuous 1/cycle throughput.
- NUM_REQS=3, pointer at 2, only req2 and req0 valid, single packets -> order 2,0,2 (wrap from 2 to 0 verified).
- Reset asserted while locked mid-instruction -> next cycle locked=0, valid_out=0, pointer=0; first subsequent grant goes to the lowest valid index.
